// File: rtl/vx_csa_seq_pkg.sv
// Shared types and sizing helpers for the sequential carry-save reducer.
package vx_csa_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_OUTPUT  = 2'd3
    } csa_seq_state_t;

    localparam int unsigned CSA_SEQ_DEFAULT_MAX_BEATS = 16;
    localparam int unsigned CSA_SEQ_CNT_W             = $clog2(CSA_SEQ_DEFAULT_MAX_BEATS) + 1;

    // Accumulator width wide enough to hold n*max_beats operands of w bits.
    function automatic int unsigned csa_seq_sum_width(input int unsigned w,
                                                      input int unsigned n,
                                                      input int unsigned max_beats);
        return w + $clog2(n * max_beats);
    endfunction

    // Beat counter width able to represent max_beats itself.
    function automatic int unsigned csa_seq_cnt_width(input int unsigned max_beats);
        return $clog2(max_beats) + 1;
    endfunction

endpackage

// File: rtl/VX_csa_tree.sv
// Combinational carry-save reduction of N operands down to a sum/carry pair.
// BALANCED=1 builds a Wallace-style tree (all full groups per level);
// BALANCED=0 builds a linear chain (one 3:2 counter per level).
// K is the weight shift applied to the majority output (1 for binary counters).
module VX_csa_tree #(
    parameter int unsigned N        = 3,
    parameter int unsigned W        = 8,
    parameter int unsigned K        = 1,
    parameter bit          BALANCED = 1'b1
) (
    input  logic [N-1:0][W-1:0] operands,
    output logic [W-1:0]        sum,
    output logic [W-1:0]        carry
);

    // Number of 3:2 counters used at a level holding c operands.
    function automatic int unsigned group_count(input int unsigned c);
        if (c <= 2) return 0;
        return BALANCED ? (c / 3) : 1;
    endfunction

    // Operand count present at level lvl.
    function automatic int unsigned level_count(input int unsigned lvl);
        int unsigned c;
        c = N;
        for (int unsigned l = 0; l < lvl; l++) c = c - group_count(c);
        return c;
    endfunction

    // Number of levels needed to reach two operands.
    function automatic int unsigned tree_depth();
        int unsigned c;
        int unsigned d;
        c = N;
        d = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (c > 2) begin
                c = c - group_count(c);
                d = d + 1;
            end
        end
        return d;
    endfunction

    localparam int unsigned DEPTH = tree_depth();

    logic [W-1:0] lvl [DEPTH+1][N];

    // Level 0 is the raw operand set.
    for (genvar j = 0; j < N; j++) begin : g_lvl0
        assign lvl[0][j] = operands[j];
    end

    // Each level compresses groups of three and passes the remainder through.
    for (genvar l = 0; l < DEPTH; l++) begin : g_level
        localparam int unsigned CNT = level_count(l);
        localparam int unsigned GRP = group_count(CNT);
        localparam int unsigned NXT = CNT - GRP;
        for (genvar j = 0; j < N; j++) begin : g_slot
            if (j < 2 * GRP) begin : g_csa
                localparam int unsigned B = 3 * (j / 2);
                if ((j % 2) == 0) begin : g_s
                    assign lvl[l+1][j] = lvl[l][B] ^ lvl[l][B+1] ^ lvl[l][B+2];
                end else begin : g_c
                    assign lvl[l+1][j] = ((lvl[l][B] & lvl[l][B+1]) |
                                          (lvl[l][B] & lvl[l][B+2]) |
                                          (lvl[l][B+1] & lvl[l][B+2])) << K;
                end
            end else if (j < NXT) begin : g_pass
                assign lvl[l+1][j] = lvl[l][j+GRP];
            end else begin : g_zero
                assign lvl[l+1][j] = '0;
            end
        end
    end

    // Final pair; a single operand has no carry term.
    if (N >= 2) begin : g_pair
        assign sum   = lvl[DEPTH][0];
        assign carry = lvl[DEPTH][1];
    end else begin : g_single
        assign sum   = lvl[DEPTH][0];
        assign carry = '0;
    end

endmodule

// File: rtl/vx_csa_seq_reducer.sv
// Multi-beat carry-save reducer: folds N operands per beat into a carry-save
// accumulator and resolves the group sum with one carry-propagate add.
// Optional macro VX_CSA_SEQ_INPUT_REG_EN inserts a registered input stage in
// front of the tree (one extra cycle of latency).
module vx_csa_seq_reducer
    import vx_csa_seq_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 16,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned SW        = csa_seq_sum_width(W, N, MAX_BEATS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                valid_in,
    output logic                                ready_in,
    input  logic [N-1:0][W-1:0]                 data_in,
    input  logic                                last_in,
    output logic                                valid_out,
    input  logic                                ready_out,
    output logic [SW-1:0]                       sum_out,
    output logic [csa_seq_cnt_width(MAX_BEATS)-1:0] beats_out,
    output logic                                trunc_out
);

    localparam int unsigned CW = csa_seq_cnt_width(MAX_BEATS);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] ACCUM   = ST_ACCUM;
    localparam logic [1:0] RESOLVE = ST_RESOLVE;
    localparam logic [1:0] OUTPUT  = ST_OUTPUT;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  trunc_q, trunc_d;
    logic                  ready_q, ready_d;
    logic                  accept_d;
    logic [SW-1:0]         acc_s_q, acc_c_q;
    logic [SW-1:0]         tree_s, tree_c;
    logic [N+1:0][SW-1:0]  tree_ops;
    logic                  acc_load, acc_clr, res_load, out_done;
    logic                  valid_q, trunc_out_q;
    logic [SW-1:0]         sum_q;
    logic [CW-1:0]         beats_q;

    logic                  fold_v;
    logic [N-1:0][W-1:0]   fold_data;
    logic                  fold_last;

    assign accept_d = (state_d == IDLE) || (state_d == ACCUM);

`ifdef VX_CSA_SEQ_INPUT_REG_EN
    logic                  in_acc;
    logic                  stg_v_q, stg_v_d;
    logic                  stg_last_q, stg_last_d;
    logic [N-1:0][W-1:0]   stg_data_q;

    assign in_acc    = valid_in && ready_q;
    assign fold_v    = stg_v_q && ((state_q == IDLE) || (state_q == ACCUM));
    assign fold_data = stg_data_q;
    assign fold_last = stg_last_q;

    // Stage occupancy: a new beat overwrites a draining one, otherwise a fold empties it.
    always_comb begin
        stg_v_d    = stg_v_q;
        stg_last_d = stg_last_q;
        if (in_acc) begin
            stg_v_d    = 1'b1;
            stg_last_d = last_in;
        end else if (fold_v) begin
            stg_v_d    = 1'b0;
        end
    end

    // Accept when the stage will be empty, or will drain a non-last beat next cycle.
    assign ready_d = !stg_v_d || (accept_d && !stg_last_d);

    // Input stage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_v_q    <= 1'b0;
            stg_last_q <= 1'b0;
            stg_data_q <= '0;
        end else begin
            stg_v_q    <= stg_v_d;
            stg_last_q <= stg_last_d;
            if (in_acc) stg_data_q <= data_in;
        end
    end
`else
    assign fold_v    = valid_in && ready_q;
    assign fold_data = data_in;
    assign fold_last = last_in;
    assign ready_d   = accept_d;
`endif

    // Tree operands: beat zero-extended to SW, followed by the accumulator pair.
    always_comb begin
        tree_ops = '0;
        for (int unsigned i = 0; i < N; i++) tree_ops[i] = SW'(fold_data[i]);
        tree_ops[N]   = acc_s_q;
        tree_ops[N+1] = acc_c_q;
    end

    VX_csa_tree #(
        .N        (N + 2),
        .W        (SW),
        .K        (1),
        .BALANCED (1'b1)
    ) u_tree (
        .operands (tree_ops),
        .sum      (tree_s),
        .carry    (tree_c)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and control decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        trunc_d  = trunc_q;
        acc_load = 1'b0;
        acc_clr  = 1'b0;
        res_load = 1'b0;
        out_done = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (fold_v) begin
                    acc_load = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (fold_last) begin
                        state_d = RESOLVE;
                    end else if (cnt_d == CW'(MAX_BEATS)) begin
                        state_d = RESOLVE;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            RESOLVE: begin
                res_load = 1'b1;
                state_d  = OUTPUT;
            end
            OUTPUT: begin
                if (ready_out) begin
                    out_done = 1'b1;
                    acc_clr  = 1'b1;
                    cnt_d    = '0;
                    trunc_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator, counter and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            sum_q       <= '0;
            beats_q     <= '0;
            trunc_out_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
            ready_q <= ready_d;
            if (acc_clr) begin
                acc_s_q <= '0;
                acc_c_q <= '0;
            end else if (acc_load) begin
                acc_s_q <= tree_s;
                acc_c_q <= tree_c;
            end
            if (res_load) begin
                sum_q       <= acc_s_q + acc_c_q;
                beats_q     <= cnt_q;
                trunc_out_q <= trunc_q;
                valid_q     <= 1'b1;
            end else if (out_done) begin
                valid_q     <= 1'b0;
            end
        end
    end

    assign ready_in  = ready_q;
    assign valid_out = valid_q;
    assign sum_out   = sum_q;
    assign beats_out = beats_q;
    assign trunc_out = trunc_out_q;

endmodule

// File: tb/tb_vx_csa_seq_reducer.sv
// Directed bench for vx_csa_seq_reducer (N=4, W=16, MAX_BEATS=16).
module tb_vx_csa_seq_reducer;
    import vx_csa_seq_pkg::*;

    localparam int unsigned N         = 4;
    localparam int unsigned W         = 16;
    localparam int unsigned MAX_BEATS = 16;
    localparam int unsigned SW        = 22;
    localparam int unsigned CW        = CSA_SEQ_CNT_W;
`ifdef VX_CSA_SEQ_INPUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                valid_in;
    logic                ready_in;
    logic [N-1:0][W-1:0] data_in;
    logic                last_in;
    logic                valid_out;
    logic                ready_out;
    logic [SW-1:0]       sum_out;
    logic [CW-1:0]       beats_out;
    logic                trunc_out;

    int n_cmp = 0;
    int n_err = 0;

    vx_csa_seq_reducer #(
        .N         (N),
        .W         (W),
        .MAX_BEATS (MAX_BEATS),
        .SW        (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .sum_out   (sum_out),
        .beats_out (beats_out),
        .trunc_out (trunc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat once ready_in is seen (bounded), let it be accepted on the next edge.
    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] d,
                              input logic last, input string tag);
        int waited;
        waited = 0;
        while (ready_in !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (ready_in !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_in: got %b want 1", tag, ready_in);
        end
        data_in[0] = a;
        data_in[1] = b;
        data_in[2] = c;
        data_in[3] = d;
        last_in    = last;
        valid_in   = 1'b1;
        tick();
        valid_in   = 1'b0;
        last_in    = 1'b0;
        data_in    = '0;
    endtask

    task automatic wait_result(input int budget, input string tag);
        int n;
        n = 0;
        while (valid_out !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL %s valid_out timeout: got %b want 1", tag, valid_out);
        end
    endtask

    task automatic consume();
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        valid_in  = 1'b0;
        last_in   = 1'b0;
        data_in   = '0;
        ready_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ready_in !== 1'b0)   begin n_err++; $display("FAIL rst ready_in: got %b want 0", ready_in); end
        n_cmp++; if (valid_out !== 1'b0)  begin n_err++; $display("FAIL rst valid_out: got %b want 0", valid_out); end
        n_cmp++; if (sum_out !== '0)      begin n_err++; $display("FAIL rst sum_out: got %0d want 0", sum_out); end
        n_cmp++; if (beats_out !== '0)    begin n_err++; $display("FAIL rst beats_out: got %0d want 0", beats_out); end
        n_cmp++; if (trunc_out !== 1'b0)  begin n_err++; $display("FAIL rst trunc_out: got %b want 0", trunc_out); end
        reset = 1'b0;
        tick();
        n_cmp++; if (ready_in !== 1'b1)   begin n_err++; $display("FAIL post_rst ready_in: got %b want 1", ready_in); end
    endtask

    task automatic test_single();
        drive_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b1, "single");
        for (int i = 1; i < LAT; i++) begin
            n_cmp++;
            if (valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL single early valid_out at t+%0d: got %b want 0", i, valid_out);
            end
            tick();
        end
        n_cmp++; if (valid_out !== 1'b1)     begin n_err++; $display("FAIL single latency valid_out: got %b want 1", valid_out); end
        n_cmp++; if (sum_out !== SW'(10))    begin n_err++; $display("FAIL single sum_out: got %0d want 10", sum_out); end
        n_cmp++; if (beats_out !== CW'(1))   begin n_err++; $display("FAIL single beats_out: got %0d want 1", beats_out); end
        n_cmp++; if (trunc_out !== 1'b0)     begin n_err++; $display("FAIL single trunc_out: got %b want 0", trunc_out); end
        consume();
        n_cmp++; if (ready_in !== 1'b1)      begin n_err++; $display("FAIL single post ready_in: got %b want 1", ready_in); end
        n_cmp++; if (valid_out !== 1'b0)     begin n_err++; $display("FAIL single post valid_out: got %b want 0", valid_out); end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) begin
            n_cmp++;
            if (ready_in !== 1'b1) begin
                n_err++;
                $display("FAIL b2b throughput ready_in beat %0d: got %b want 1", b, ready_in);
            end
            drive_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, (b == 2), "b2b");
        end
        wait_result(8, "b2b");
        n_cmp++; if (sum_out !== SW'(786420)) begin n_err++; $display("FAIL b2b sum_out: got %0d want 786420", sum_out); end
        n_cmp++; if (beats_out !== CW'(3))    begin n_err++; $display("FAIL b2b beats_out: got %0d want 3", beats_out); end
        n_cmp++; if (trunc_out !== 1'b0)      begin n_err++; $display("FAIL b2b trunc_out: got %b want 0", trunc_out); end
        consume();
    endtask

    task automatic test_trunc();
        for (int b = 0; b < 16; b++) drive_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b0, "trunc");
        wait_result(8, "trunc");
        n_cmp++; if (sum_out !== SW'(64))     begin n_err++; $display("FAIL trunc sum_out: got %0d want 64", sum_out); end
        n_cmp++; if (beats_out !== CW'(16))   begin n_err++; $display("FAIL trunc beats_out: got %0d want 16", beats_out); end
        n_cmp++; if (trunc_out !== 1'b1)      begin n_err++; $display("FAIL trunc trunc_out: got %b want 1", trunc_out); end
        consume();
        drive_beat(16'd2, 16'd0, 16'd0, 16'd0, 1'b1, "after_trunc");
        wait_result(8, "after_trunc");
        n_cmp++; if (sum_out !== SW'(2))      begin n_err++; $display("FAIL after_trunc sum_out: got %0d want 2", sum_out); end
        n_cmp++; if (beats_out !== CW'(1))    begin n_err++; $display("FAIL after_trunc beats_out: got %0d want 1", beats_out); end
        n_cmp++; if (trunc_out !== 1'b0)      begin n_err++; $display("FAIL after_trunc trunc_out: got %b want 0", trunc_out); end
        consume();
    endtask

    task automatic test_stall();
        drive_beat(16'd7, 16'd8, 16'd9, 16'd10, 1'b1, "stall");
        wait_result(8, "stall");
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (valid_out !== 1'b1)    begin n_err++; $display("FAIL stall[%0d] valid_out: got %b want 1", k, valid_out); end
            n_cmp++; if (sum_out !== SW'(34))   begin n_err++; $display("FAIL stall[%0d] sum_out: got %0d want 34", k, sum_out); end
            n_cmp++; if (beats_out !== CW'(1))  begin n_err++; $display("FAIL stall[%0d] beats_out: got %0d want 1", k, beats_out); end
            n_cmp++; if (ready_in !== 1'b0)     begin n_err++; $display("FAIL stall[%0d] ready_in: got %b want 0", k, ready_in); end
            tick();
        end
        consume();
        n_cmp++; if (valid_out !== 1'b0)        begin n_err++; $display("FAIL stall release valid_out: got %b want 0", valid_out); end
        n_cmp++; if (ready_in !== 1'b1)         begin n_err++; $display("FAIL stall release ready_in: got %b want 1", ready_in); end
    endtask

    task automatic test_reset_mid();
        drive_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b0, "rst_mid");
        drive_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b0, "rst_mid");
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (ready_in !== 1'b0)   begin n_err++; $display("FAIL rst_mid ready_in: got %b want 0", ready_in); end
        n_cmp++; if (valid_out !== 1'b0)  begin n_err++; $display("FAIL rst_mid valid_out: got %b want 0", valid_out); end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (ready_in !== 1'b1)   begin n_err++; $display("FAIL rst_mid post ready_in: got %b want 1", ready_in); end
        n_cmp++; if (valid_out !== 1'b0)  begin n_err++; $display("FAIL rst_mid post valid_out: got %b want 0", valid_out); end
        drive_beat(16'd5, 16'd0, 16'd0, 16'd0, 1'b1, "rst_new");
        wait_result(8, "rst_new");
        n_cmp++; if (sum_out !== SW'(5))     begin n_err++; $display("FAIL rst_new sum_out: got %0d want 5", sum_out); end
        n_cmp++; if (beats_out !== CW'(1))   begin n_err++; $display("FAIL rst_new beats_out: got %0d want 1", beats_out); end
        n_cmp++; if (trunc_out !== 1'b0)     begin n_err++; $display("FAIL rst_new trunc_out: got %b want 0", trunc_out); end
        consume();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_trunc();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
